// File: rtl/rcon_ctrl.sv
// Builds the AES round-constant table in the external RCON memory, then serves single-word reads over valid/ready.
// Optional read-back check of the loaded table is compiled in with RCON_VERIFY_EN.
module rcon_ctrl #(
  parameter int         NUM_RCON  = 10,
  parameter int         TIMEOUT   = 4,
  parameter logic [7:0] RCON_INIT = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_start,
  output logic       init_done,
  output logic       init_err,
  input  logic       req_valid,
  input  logic [3:0] req_round,
  output logic       req_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [7:0] mem_in,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_addr0,
  output logic       mem_wr_en,
  output logic       mem_rd_en,
  input  logic [7:0] mem_out,
  input  logic       mem_done
);

  localparam int         IDX_W     = $clog2(NUM_RCON + 1);
  localparam int         CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [3:0] MAX_ROUND = 4'(NUM_RCON);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
`ifdef RCON_VERIFY_EN
    VERIFY,
`endif
    READY,
    RD_ISSUE,
    RD_WAIT,
    RESP
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [7:0]         rcon_reg, rcon_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               init_done_reg, init_done_next;
  logic               req_ready_reg, req_ready_next;
  logic               rsp_valid_reg, rsp_valid_next;
  logic [7:0]         rsp_data_reg, rsp_data_next;
  logic               rsp_err_reg, rsp_err_next;
  logic [7:0]         mem_in_reg, mem_in_next;
  logic [7:0]         mem_addr_reg, mem_addr_next;
  logic [7:0]         mem_addr0_reg, mem_addr0_next;
  logic               mem_wr_en_reg, mem_wr_en_next;
  logic               mem_rd_en_reg, mem_rd_en_next;
  logic               load_go;
  logic               wait_end;
`ifdef RCON_VERIFY_EN
  logic               init_err_reg, init_err_next;
  logic               vfy_reg, vfy_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      rcon_reg      <= RCON_INIT;
      cnt_reg       <= '0;
      init_done_reg <= 1'b0;
      req_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= 8'h00;
      rsp_err_reg   <= 1'b0;
      mem_in_reg    <= 8'h00;
      mem_addr_reg  <= 8'h00;
      mem_addr0_reg <= 8'h00;
      mem_wr_en_reg <= 1'b0;
      mem_rd_en_reg <= 1'b0;
`ifdef RCON_VERIFY_EN
      init_err_reg  <= 1'b0;
      vfy_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      rcon_reg      <= rcon_next;
      cnt_reg       <= cnt_next;
      init_done_reg <= init_done_next;
      req_ready_reg <= req_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_err_reg   <= rsp_err_next;
      mem_in_reg    <= mem_in_next;
      mem_addr_reg  <= mem_addr_next;
      mem_addr0_reg <= mem_addr0_next;
      mem_wr_en_reg <= mem_wr_en_next;
      mem_rd_en_reg <= mem_rd_en_next;
`ifdef RCON_VERIFY_EN
      init_err_reg  <= init_err_next;
      vfy_reg       <= vfy_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    rcon_next      = rcon_reg;
    cnt_next       = cnt_reg;
    init_done_next = init_done_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_err_next   = rsp_err_reg;
    mem_in_next    = mem_in_reg;
    mem_addr_next  = mem_addr_reg;
    mem_addr0_next = mem_addr0_reg;
    mem_wr_en_next = 1'b0;
    rsp_valid_next = 1'b0;
    load_go        = 1'b0;
    wait_end       = mem_done || (cnt_reg == CNT_W'(TIMEOUT - 1));
`ifdef RCON_VERIFY_EN
    init_err_next  = init_err_reg;
    vfy_next       = vfy_reg;
`endif

    unique case (state_reg)
      IDLE: load_go = init_start;
      LOAD: begin
        if (idx_reg == IDX_W'(NUM_RCON)) begin
`ifdef RCON_VERIFY_EN
          state_next = VERIFY;
          idx_next   = '0;
          rcon_next  = RCON_INIT;
          vfy_next   = 1'b1;
`else
          init_done_next = 1'b1;
          state_next     = READY;
`endif
        end else begin
          mem_wr_en_next = 1'b1;
          mem_addr_next  = 8'(idx_reg);
          mem_in_next    = rcon_reg;
          idx_next       = idx_reg + IDX_W'(1);
          rcon_next      = xtime(rcon_reg);
        end
      end
`ifdef RCON_VERIFY_EN
      VERIFY: begin
        mem_addr0_next = 8'(idx_reg);
        state_next     = RD_ISSUE;
      end
`endif
      READY: begin
        // A reload request outranks a read arriving in the same cycle.
        if (init_start) begin
          load_go = 1'b1;
        end else if (req_valid && req_ready_reg) begin
          if (req_round == 4'd0 || req_round > MAX_ROUND) begin
            rsp_data_next = 8'h00;
            rsp_err_next  = 1'b1;
            state_next    = RESP;
          end else begin
            mem_addr0_next = {4'd0, req_round} - 8'd1;
            state_next     = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        cnt_next   = '0;
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (wait_end) begin
`ifdef RCON_VERIFY_EN
          if (vfy_reg) begin
            if (!mem_done || mem_out != rcon_reg) init_err_next = 1'b1;
            rcon_next = xtime(rcon_reg);
            if (idx_reg == IDX_W'(NUM_RCON - 1)) begin
              init_done_next = 1'b1;
              vfy_next       = 1'b0;
              state_next     = READY;
            end else begin
              idx_next   = idx_reg + IDX_W'(1);
              state_next = VERIFY;
            end
          end else
`endif
          begin
            rsp_data_next = mem_done ? mem_out : 8'h00;
            rsp_err_next  = !mem_done;
            state_next    = RESP;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RESP: state_next = READY;
      default: state_next = IDLE;
    endcase

    if (load_go) begin
      state_next     = LOAD;
      idx_next       = '0;
      rcon_next      = RCON_INIT;
      init_done_next = 1'b0;
`ifdef RCON_VERIFY_EN
      init_err_next  = 1'b0;
      vfy_next       = 1'b0;
`endif
    end

    // Handshake and strobe outputs are registered images of the state being entered.
    req_ready_next = (state_next == READY);
    mem_rd_en_next = (state_next == RD_ISSUE);
    if (state_next == RESP) rsp_valid_next = 1'b1;
  end

  assign init_done = init_done_reg;
  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;
  assign mem_in    = mem_in_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_addr0 = mem_addr0_reg;
  assign mem_wr_en = mem_wr_en_reg;
  assign mem_rd_en = mem_rd_en_reg;
`ifdef RCON_VERIFY_EN
  assign init_err  = init_err_reg;
`else
  assign init_err  = 1'b0;
`endif

endmodule

// File: doc/rcon_ctrl.md
Name: rcon_ctrl

Overview:
- Sequencer and access controller for the 10-entry AES round-constant memory (RCON).
- After reset and a start pulse, it generates the round constants in GF(2^8) and writes them into the memory.
- It then serves single-word read requests from the key-expansion block through a valid/ready handshake, using the memory's rd_en/done protocol.
- All memory traffic in the key schedule goes through this block.

Parameters:
- NUM_RCON, 10, number of round constants generated and stored (addresses 0..NUM_RCON-1).
- TIMEOUT, 4, maximum RD_WAIT cycles to wait for mem_done before the access is flagged as an error.
- RCON_INIT, 8'h01, first round constant (value at address 0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- init_start  in  1  pulse; starts (re)load of the memory.
- init_done  out  1  level; memory loaded and block ready for requests.
- init_err  out  1  sticky; verify mismatch (RCON_VERIFY_EN only, else 0).
- req_valid  in  1  read request from key expansion.
- req_round  in  4  AES round number, 1..10.
- req_ready  out  1  request accepted when valid&&ready.
- rsp_valid  out  1  one-cycle pulse; response present.
- rsp_data  out  8  round constant; 8'h00 on error.
- rsp_err  out  1  qualifies rsp_valid: bad round or timeout.
- mem_in  out  8  memory write data.
- mem_addr  out  8  memory write address.
- mem_addr0  out  8  memory read address.
- mem_wr_en  out  1  memory write enable.
- mem_rd_en  out  1  memory read enable.
- mem_out  in  8  memory read data.
- mem_done  in  1  memory read-complete flag.

Behaviour:
- Outputs: all registered.
- Reset values: every output is 0; FSM is IDLE; the internal rcon register is RCON_INIT.
- Memory contents: not cleared by rst.
- FSM states: IDLE, LOAD, (VERIFY), READY, RD_ISSUE, RD_WAIT, RESP.
- IDLE:
  - req_ready=0.
  - init_start=1 moves to LOAD; the write index is cleared and rcon is set to RCON_INIT.
- LOAD:
  - For each index i = 0..NUM_RCON-1, one cycle each: mem_wr_en=1, mem_addr=i, mem_in=rcon.
  - rcon advances by xtime: rcon<<1, XOR 8'h1B if the old bit 7 was 1.
  - The stored sequence is 01,02,04,08,10,20,40,80,1B,36.
  - The cycle after the last write: mem_wr_en=0, init_done=1, state moves to READY (or VERIFY if enabled).
- READY:
  - req_ready=1.
  - On valid&&ready, req_round is latched and req_ready drops the next cycle.
  - If req_round is 0 or greater than NUM_RCON: go directly to RESP with rsp_err=1 and rsp_data=0. No memory access is made.
  - Otherwise: mem_addr0=req_round-1 and go to RD_ISSUE.
- RD_ISSUE:
  - mem_rd_en=1 for exactly one cycle, then RD_WAIT.
- RD_WAIT:
  - mem_rd_en=0.
  - If mem_done=1: capture mem_out and go to RESP with rsp_err=0.
  - Else count cycles; after TIMEOUT cycles go to RESP with rsp_err=1 and rsp_data=0.
- RESP:
  - rsp_valid=1 for one cycle, then READY.
- Latency (accept at cycle T, normal memory): mem_rd_en high in T+1; mem_done seen in T+2; rsp_valid in T+3. Next accept is possible at T+4.
- Simultaneous events:
  - init_start in READY with req_valid: init_start wins and req is not accepted. init_done drops and the memory is reloaded.
  - init_start in RD_ISSUE, RD_WAIT or RESP: ignored.
  - init_start during LOAD: ignored.
- mem_wr_en and mem_rd_en are never asserted in the same cycle.
- Reset mid-LOAD or mid-read: returns to IDLE next cycle; rsp_valid is not issued; init_done=0.

Optional Feature:
- Macro: RCON_VERIFY_EN.
- Defined:
  - After LOAD, the VERIFY state reads back every address 0..9 with the same issue/wait/timeout sequence, comparing each value against a regenerated xtime sequence.
  - Any mismatch or timeout sets init_err, which is sticky until rst or the next init_start.
  - init_done is asserted only after verify finishes, whether or not it passed.
- Undefined: no VERIFY state; init_err is tied to 0; init_done is asserted immediately after LOAD.

Test Plan:
- Load sequence: rst, then init_start pulse → 10 consecutive writes with addr 0..9 and data 01,02,04,08,10,20,40,80,1B,36; init_done=1 one cycle after the last write.
- Normal reads: req_round=1, then 9, then 10 → rsp_data 01, 1B, 36; rsp_err=0; rsp_valid exactly 3 cycles after each accept.
- Bad round: req_round=0 and req_round=11 → rsp_valid with rsp_err=1, rsp_data=00; mem_rd_en never asserted.
- Timeout: model holds mem_done=0 → rsp_err=1 after TIMEOUT=4 wait cycles; FSM returns to READY.
- Reset and collisions: rst asserted mid-LOAD at write 5 → IDLE, init_done=0, a fresh init_start rewrites all 10 entries. init_start together with req_valid in READY → req not accepted and reload starts.
- Verify (RCON_VERIFY_EN): corrupt memory entry 3 to 8'hFF during verify → init_err=1 and init_done=1 after the verify pass.
